// File: rtl/fetch_sequencer.sv
// fetch_sequencer: MIPS32 instruction-fetch controller (pc/chip_en sequencing, delay-slot branches, stall hold buffer, flush discard)
// Ports: clk/rst (sync, active-high); stall, branch_flag/branch_target, flush/new_pc from the pipeline;
//        imem_rdy/imem_rdata from instruction memory; pc/chip_en to memory; if_pc/if_inst/if_valid to decode.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        imem_rdy,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        chip_en,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);
  typedef enum logic [1:0] {S_RESET, S_FETCH, S_HOLD, S_DISCARD} state_t;
  state_t state;
  logic redir_pend;
  logic [31:0] redir_pc, hold_pc, hold_inst;
  logic eff_pend;
  logic [31:0] eff_pc, pc_next;
  // A branch arriving in the cycle the access completes is used directly.
  assign eff_pend = branch_flag | redir_pend;
  assign eff_pc = branch_flag ? branch_target : redir_pc;
  assign pc_next = eff_pend ? eff_pc : pc + 32'd4;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RESET;
      pc <= RESET_PC;
      chip_en <= 1'b0;
      if_pc <= '0;
      if_inst <= '0;
      if_valid <= 1'b0;
      redir_pend <= 1'b0;
      redir_pc <= '0;
      hold_pc <= '0;
      hold_inst <= '0;
    end else if (flush && state != S_RESET) begin
      if_valid <= 1'b0;
      redir_pend <= 1'b0;
      chip_en <= 1'b1;
      // An access still waiting on memory must not have its address changed.
      if ((state == S_FETCH || state == S_DISCARD) && !imem_rdy) begin
        redir_pc <= new_pc;
        state <= S_DISCARD;
      end else begin
        pc <= new_pc;
        state <= S_FETCH;
      end
    end else begin
      case (state)
        S_RESET: begin
          state <= S_FETCH;
          chip_en <= 1'b1;
        end
        S_FETCH: begin
          redir_pend <= eff_pend;
          redir_pc <= eff_pc;
          if (imem_rdy && !stall) begin
            if_inst <= imem_rdata;
            if_pc <= pc;
            if_valid <= 1'b1;
            pc <= pc_next;
            redir_pend <= 1'b0;
          end else if (imem_rdy) begin
            hold_pc <= pc;
            hold_inst <= imem_rdata;
            state <= S_HOLD;
            chip_en <= 1'b0;
          end else if (!stall) begin
            if_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          redir_pend <= eff_pend;
          redir_pc <= eff_pc;
          if (!stall) begin
            if_inst <= hold_inst;
            if_pc <= hold_pc;
            if_valid <= 1'b1;
            pc <= pc_next;
            redir_pend <= 1'b0;
            state <= S_FETCH;
            chip_en <= 1'b1;
          end
        end
        S_DISCARD: begin
          if (imem_rdy) begin
            pc <= redir_pc;
            state <= S_FETCH;
          end
        end
      endcase
    end
  end
endmodule
